// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, special instruction encodings
// and the fetch-stage state encoding.
package cpu_pkg;

    localparam int unsigned PC_W    = 8;
    localparam int unsigned INSTR_W = 16;

    localparam logic [INSTR_W-1:0] HALT_WORD = 16'h0001;
    localparam logic [INSTR_W-1:0] NOP_WORD  = 16'h0000;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit.sv
// IF stage: owns the PC, sequences the IRAM boot load and registers each
// fetched word into IF/ID, with stall, branch redirect/flush and HALT stop.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter int unsigned     BOOT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               stall,
    input  logic               br_taken,
    input  logic [PC_W-1:0]    br_target,
    input  logic [INSTR_W-1:0] iram_q,
    output logic [PC_W-1:0]    iram_addr,
    output logic               iram_load,
    output logic [INSTR_W-1:0] ir,
    output logic [PC_W-1:0]    pc_out,
    output logic [PC_W-1:0]    pc_plus2,
    output logic               valid,
    output logic               halted
);

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    fetch_state_t    state;
    logic [PC_W-1:0] pc;
    logic [3:0]      boot_cnt;
    logic [PC_W-1:0] redirect_pc;

    // Instructions are halfword aligned, so the redirect LSB is dropped.
    assign redirect_pc = {br_target[PC_W-1:1], 1'b0};
    assign iram_addr   = pc;
    assign pc_plus2    = pc_out + PC_W'(2);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_BOOT;
            pc        <= RESET_PC;
            boot_cnt  <= '0;
            ir        <= NOP_WORD;
            pc_out    <= '0;
            valid     <= 1'b0;
            halted    <= 1'b0;
            iram_load <= 1'b1;
        end else begin
            case (state)
                S_BOOT: begin
                    boot_cnt <= boot_cnt + 4'd1;
                    if (boot_cnt == BOOT_LAST) begin
                        state     <= S_RUN;
                        iram_load <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (br_taken) begin
                        pc    <= redirect_pc;
                        ir    <= NOP_WORD;
                        valid <= 1'b0;
                    end else if (!stall) begin
                        ir     <= iram_q;
                        pc_out <= pc;
                        valid  <= 1'b1;
                        // PC stays on the HALT word so a later redirect is the only way out.
                        if (iram_q == HALT_WORD) begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end else begin
                            pc <= pc + PC_W'(2);
                        end
                    end
                end
                S_HALT: begin
                    if (br_taken) begin
                        pc     <= redirect_pc;
                        ir     <= NOP_WORD;
                        valid  <= 1'b0;
                        halted <= 1'b0;
                        state  <= S_RUN;
                    end else if (!stall) begin
                        valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_BOOT;
                    iram_load <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: boot, streaming, stall, branch flush,
// HALT delivery/exit, PC wrap and asynchronous reset mid-stream.
module tb_instr_fetch_unit;
    import cpu_pkg::*;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               stall;
    logic               br_taken;
    logic [PC_W-1:0]    br_target;
    logic [INSTR_W-1:0] iram_q;
    logic [PC_W-1:0]    iram_addr;
    logic               iram_load;
    logic [INSTR_W-1:0] ir;
    logic [PC_W-1:0]    pc_out;
    logic [PC_W-1:0]    pc_plus2;
    logic               valid;
    logic               halted;

    logic [INSTR_W-1:0] mem [0:127];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Word i lives at byte address 2*i and reads as 16'hA000 | i, except
    // the HALT word at 0x3A and a NOP at 0x12.
    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 16'hA000 | 16'(i);
        mem[29] = 16'h0001;
        mem[9]  = 16'h0000;
    end

    assign iram_q = mem[iram_addr[7:1]];

    instr_fetch_unit #(.RESET_PC(8'h00), .BOOT_CYCLES(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .stall     (stall),
        .br_taken  (br_taken),
        .br_target (br_target),
        .iram_q    (iram_q),
        .iram_addr (iram_addr),
        .iram_load (iram_load),
        .ir        (ir),
        .pc_out    (pc_out),
        .pc_plus2  (pc_plus2),
        .valid     (valid),
        .halted    (halted)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = '0;
        tick(); tick();
        chk("rst_load",  16'(iram_load), 16'h1);
        chk("rst_valid", 16'(valid),     16'h0);
        chk("rst_ir",    ir,             16'h0000);
        chk("rst_pcout", 16'(pc_out),    16'h00);
        chk("rst_halt",  16'(halted),    16'h0);
        chk("rst_addr",  16'(iram_addr), 16'h00);

        // Boot: load high for exactly two edges after release
        reset_n = 1'b1;
        tick();
        chk("boot1_load",  16'(iram_load), 16'h1);
        tick();
        chk("boot2_load",  16'(iram_load), 16'h0);
        chk("boot2_valid", 16'(valid),     16'h0);
        chk("boot2_addr",  16'(iram_addr), 16'h00);

        // Stream
        tick();
        chk("s0_valid", 16'(valid),     16'h1);
        chk("s0_ir",    ir,             16'hA000);
        chk("s0_pcout", 16'(pc_out),    16'h00);
        chk("s0_addr",  16'(iram_addr), 16'h02);
        tick();
        chk("s1_ir",    ir,             16'hA001);
        chk("s1_addr",  16'(iram_addr), 16'h04);
        tick();
        chk("s2_ir",    ir,             16'hA002);
        chk("s2_pcout", 16'(pc_out),    16'h04);
        chk("s2_pc2",   16'(pc_plus2),  16'h06);
        chk("s2_addr",  16'(iram_addr), 16'h06);

        // Stall three cycles at PC 0x06
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_addr",  16'(iram_addr), 16'h06);
            chk("stall_ir",    ir,             16'hA002);
            chk("stall_pcout", 16'(pc_out),    16'h04);
            chk("stall_valid", 16'(valid),     16'h1);
        end
        stall = 1'b0;
        tick();
        chk("resume_ir",    ir,             16'hA003);
        chk("resume_pcout", 16'(pc_out),    16'h06);
        chk("resume_addr",  16'(iram_addr), 16'h08);
        chk("resume_pc2",   16'(pc_plus2),  16'h08);

        // Branch with stall asserted: branch wins, LSB dropped
        br_taken = 1'b1; br_target = 8'h29; stall = 1'b1;
        tick();
        chk("br_addr",  16'(iram_addr), 16'h28);
        chk("br_valid", 16'(valid),     16'h0);
        chk("br_ir",    ir,             16'h0000);
        br_taken = 1'b0; stall = 1'b0;
        tick();
        chk("br_tgt_ir",    ir,             16'hA014);
        chk("br_tgt_valid", 16'(valid),     16'h1);
        chk("br_tgt_pcout", 16'(pc_out),    16'h28);
        chk("br_tgt_addr",  16'(iram_addr), 16'h2A);

        // Halt at 0x3A
        br_taken = 1'b1; br_target = 8'h38;
        tick();
        br_taken = 1'b0;
        tick();
        chk("pre_halt_ir", ir,             16'hA01C);
        chk("pre_halt_ad", 16'(iram_addr), 16'h3A);
        tick();
        chk("halt_ir",    ir,             16'h0001);
        chk("halt_valid", 16'(valid),     16'h1);
        chk("halt_flag",  16'(halted),    16'h1);
        chk("halt_addr",  16'(iram_addr), 16'h3A);
        stall = 1'b1;
        tick();
        chk("halt_stall_valid", 16'(valid), 16'h1);
        stall = 1'b0;
        tick();
        chk("halt_once_valid", 16'(valid),     16'h0);
        chk("halt_hold_addr",  16'(iram_addr), 16'h3A);
        tick();
        chk("halt_term_valid", 16'(valid),     16'h0);
        chk("halt_term_flag",  16'(halted),    16'h1);
        chk("halt_term_addr",  16'(iram_addr), 16'h3A);

        // Older branch releases the halt
        br_taken = 1'b1; br_target = 8'h10;
        tick();
        br_taken = 1'b0;
        chk("unhalt_flag",  16'(halted),    16'h0);
        chk("unhalt_addr",  16'(iram_addr), 16'h10);
        chk("unhalt_valid", 16'(valid),     16'h0);
        tick();
        chk("unhalt_ir",    ir,             16'hA008);
        chk("unhalt_pcout", 16'(pc_out),    16'h10);
        tick();
        chk("nop_ir",    ir,          16'h0000);
        chk("nop_valid", 16'(valid),  16'h1);
        chk("nop_flag",  16'(halted), 16'h0);

        // Wrap 0xFC -> 0xFE -> 0x00
        br_taken = 1'b1; br_target = 8'hFC;
        tick();
        br_taken = 1'b0;
        chk("wrap_addr0", 16'(iram_addr), 16'hFC);
        tick();
        chk("wrap_ir0",   ir,             16'hA07E);
        chk("wrap_addr1", 16'(iram_addr), 16'hFE);
        tick();
        chk("wrap_ir1",   ir,             16'hA07F);
        chk("wrap_pcout", 16'(pc_out),    16'hFE);
        chk("wrap_pc2",   16'(pc_plus2),  16'h00);
        chk("wrap_addr2", 16'(iram_addr), 16'h00);
        tick();
        chk("wrap_ir2",   ir,             16'hA000);
        chk("wrap_addr3", 16'(iram_addr), 16'h02);

        // Asynchronous reset mid-stream
        reset_n = 1'b0;
        #1;
        chk("arst_ir",    ir,             16'h0000);
        chk("arst_valid", 16'(valid),     16'h0);
        chk("arst_pcout", 16'(pc_out),    16'h00);
        chk("arst_load",  16'(iram_load), 16'h1);
        chk("arst_addr",  16'(iram_addr), 16'h00);
        tick();
        reset_n = 1'b1;
        tick();
        chk("reboot1_load", 16'(iram_load), 16'h1);
        tick();
        chk("reboot2_load", 16'(iram_load), 16'h0);
        chk("reboot2_valid", 16'(valid),    16'h0);
        tick();
        chk("reboot_ir",    ir,             16'hA000);
        chk("reboot_valid", 16'(valid),     16'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
